mem_wb_stage: RTL

- Consumer end of the stage-3 pipeline register. Takes the registered memory-bypass, memory-write-enable, aux (register write enable) and 5-bit write address, plus ALU result and store data.
- Either passes the ALU result straight to writeback, or performs one data-memory transaction over a req/ack handshake. While that transaction is outstanding, it stalls upstream.
- Drives the register-file write port. Sits between the stage-3 register and the register file / data memory of the 16-bit CPU.

---
 rtl/mem_wb_stage_if.sv | 31 +++
 rtl/mem_wb_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if
// Data-memory request/acknowledge bus between the MEM/WB stage and the data
// memory.
//   req   : request held for the whole transaction      (master -> slave)
//   we    : 1 = store, 0 = load                         (master -> slave)
//   addr  : word address, stable while req=1            (master -> slave)
//   wdata : store data, stable while req=1              (master -> slave)
//   ack   : completion, only meaningful while req=1     (slave  -> master)
//   rdata : load data, valid in the cycle ack=1         (slave  -> master)
// ---------------------------------------------------------------------------
interface mem_wb_stage_if #(
    parameter int unsigned DATA_W = 16
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// Consumer side of the stage-3 pipeline register of the 16-bit CPU. Each valid
// instruction either writes the ALU result straight back to the register file
// (bypass) or performs one data-memory load/store over the req/ack bus, with
// upstream stalled until the transaction completes or times out.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   valid_in        : stage-3 holds a valid instruction
//   mem_bypass_in   : 1 = no memory access, write back alu_result_in
//   mem_we_in       : 1 = store, 0 = load (ignored on bypass)
//   aux_in          : register-file write enable for this instruction
//   wa_in           : destination register address
//   alu_result_in   : ALU result / memory address
//   store_data_in   : store data
//   stall_out       : upstream must hold all *_in stable
//   dmem            : data-memory bus (master side)
//   rf_we/wa/wd     : register-file write port, rf_we is a one-cycle pulse
//   bus_err         : sticky memory-timeout flag
//   err_clr         : clears bus_err (a simultaneous new timeout wins)
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              mem_bypass_in,
    input  logic              mem_we_in,
    input  logic              aux_in,
    input  logic [4:0]        wa_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] store_data_in,
    output logic              stall_out,
    mem_wb_stage_if.master    dmem,
    output logic              rf_we,
    output logic [4:0]        rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              bus_err,
    input  logic              err_clr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Last WAIT cycle allowed before the transaction is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pend_we_q, pend_we_d;   // load will write the RF on ack
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_wa_q, rf_wa_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic              bus_err_q, bus_err_d;

    logic              ack_seen;

    // A stray ack while no request is outstanding (e.g. after reset) is ignored.
    assign ack_seen = dmem.ack & req_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pend_we_d = pend_we_q;
        rf_we_d   = 1'b0;
        rf_wa_d   = rf_wa_q;
        rf_wd_d   = rf_wd_q;
        bus_err_d = bus_err_q & ~err_clr;

        unique case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    if (mem_bypass_in) begin
                        rf_we_d = aux_in & (wa_in != 5'd0);
                        rf_wa_d = wa_in;
                        rf_wd_d = alu_result_in;
                    end else begin
                        state_d   = ST_WAIT;
                        cnt_d     = '0;
                        req_d     = 1'b1;
                        we_d      = mem_we_in;
                        addr_d    = alu_result_in;
                        wdata_d   = store_data_in;
                        rf_wa_d   = wa_in;
                        pend_we_d = aux_in & ~mem_we_in & (wa_in != 5'd0);
                    end
                end
            end

            ST_WAIT: begin
                // Ack is checked before the timeout so it wins a tie.
                if (ack_seen) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        rf_we_d = pend_we_q;
                        rf_wd_d = dmem.rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pend_we_q <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            pend_we_q <= pend_we_d;
            rf_we_q   <= rf_we_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign stall_out  = (state_q == ST_WAIT);
    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign rf_we      = rf_we_q;
    assign rf_wa      = rf_wa_q;
    assign rf_wd      = rf_wd_q;
    assign bus_err    = bus_err_q;

endmodule
